// File: rtl/i2s_stereo_receiver.sv
// i2s_stereo_receiver: I2S / left-justified stereo deserialiser presenting L+R words with a per-frame dvalid pulse
module i2s_stereo_receiver #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              lrclk,
  input  logic              sdin,
  input  logic              fmt,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              dvalid,
  output logic              slot_err
);
  localparam int CW = $clog2(SLOT_W + 1);
  localparam logic [CW-1:0] DW = CW'(DATA_W);
  localparam logic [CW-1:0] SW = CW'(SLOT_W);
  typedef enum logic [1:0] {SYNC, CAPT, DONE} state_t;
  state_t state, state_n;
  logic lr_q, fmt_q, have_l, err_l, err_r, pend;
  logic slot_e, go, full, app, latch, lat_err;
  logic [DATA_W-1:0] shreg, hold_l, hold_r, wv, lat_word;
  logic [CW-1:0] bit_cnt, cnt_e;
  assign slot_e = lrclk ^ lr_q;
  assign go = slot_e && (state != SYNC || !lrclk);
  always_ff @(posedge sclk or posedge rst)
    if (rst) state <= SYNC;
    else state <= state_n;
  always_comb state_n = go ? CAPT : (state == CAPT && full) ? DONE : state;
  always_comb begin
    full = bit_cnt == DW;
    app = slot_e && state == CAPT && !fmt_q && !full;
    cnt_e = bit_cnt + CW'(app);
    wv = app ? DATA_W'({shreg, sdin}) : shreg;
    lat_word = slot_e ? wv << (DW - cnt_e) : shreg;
    latch = state == CAPT && (slot_e || full);
    lat_err = slot_e && cnt_e != DW;
  end
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      lr_q <= 1'b1;
      fmt_q <= 1'b0;
      have_l <= 1'b0;
      err_l <= 1'b0;
      err_r <= 1'b0;
      pend <= 1'b0;
      shreg <= '0;
      hold_l <= '0;
      hold_r <= '0;
      bit_cnt <= '0;
      left_data <= '0;
      right_data <= '0;
      dvalid <= 1'b0;
      slot_err <= 1'b0;
    end else begin
      lr_q <= lrclk;
      pend <= latch && lr_q;
      dvalid <= pend;
      slot_err <= pend && (err_l || err_r || !have_l);
      if (pend) begin
        left_data <= have_l ? hold_l : '0;
        right_data <= hold_r;
        have_l <= 1'b0;
        err_l <= 1'b0;
        err_r <= 1'b0;
      end
      if (latch && !lr_q) begin
        hold_l <= lat_word;
        err_l <= lat_err;
        have_l <= 1'b1;
      end
      if (latch && lr_q) begin
        hold_r <= lat_word;
        err_r <= lat_err;
      end
      if (go) begin
        fmt_q <= fmt;
        shreg <= fmt ? DATA_W'(sdin) : '0;
        bit_cnt <= CW'(fmt);
      end else if (state == CAPT && !full) begin
        shreg <= DATA_W'({shreg, sdin});
        bit_cnt <= bit_cnt + CW'(1);
      end else if (bit_cnt != SW) bit_cnt <= bit_cnt + CW'(1);
    end
endmodule

// File: tb/tb_i2s_stereo_receiver.sv
// tb_i2s_stereo_receiver: table-driven and sequence checks of the stereo receiver
module tb_i2s_stereo_receiver;
  logic sclk = 0, rst = 1, lrclk = 1, sdin = 0, fmt = 0;
  logic [23:0] l1, r1;
  logic [15:0] l2, r2;
  logic dv1, dv2, e1, e2;
  always #5 sclk = ~sclk;
  i2s_stereo_receiver u1 (.sclk(sclk), .rst(rst), .lrclk(lrclk), .sdin(sdin), .fmt(fmt),
    .left_data(l1), .right_data(r1), .dvalid(dv1), .slot_err(e1));
  i2s_stereo_receiver #(.DATA_W(16), .SLOT_W(64)) u2 (.sclk(sclk), .rst(rst), .lrclk(lrclk), .sdin(sdin), .fmt(fmt),
    .left_data(l2), .right_data(r2), .dvalid(dv2), .slot_err(e2));
  typedef struct {logic [23:0] l, r; logic e; int c;} rec_t;
  typedef struct {logic f, dly; int slen; logic [23:0] l, r, el, er; logic ee;} vec_t;
  rec_t q1[$], q2[$];
  vec_t tv[9];
  int rs[9];
  int cyc = 0, total = 0, bad = 0, r_start = 0;
  logic prev = 0;
  always @(posedge sclk) cyc <= cyc + 1;
  always @(negedge sclk) begin
    if (dv1) q1.push_back('{l1, r1, e1, cyc});
    if (dv2) q2.push_back('{24'(l2), 24'(r2), e2, cyc});
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic send_slot(logic lr, logic f, logic dly, logic [63:0] v, int slen);
    logic b;
    for (int i = 0; i < slen; i++) begin
      b = v[63-i];
      @(negedge sclk);
      lrclk = lr;
      fmt = f;
      if (i == 0 && lr) r_start = cyc + 1;
      sdin = dly ? prev : b;
      prev = b;
    end
  endtask
  task automatic send_frame(logic f, logic dly, logic [63:0] lv, logic [63:0] rv, int slen);
    send_slot(1'b0, f, dly, lv, slen);
    send_slot(1'b1, f, dly, rv, slen);
  endtask
  task automatic flush();
    repeat (4) begin
      @(negedge sclk);
      lrclk = 0;
      sdin = 0;
    end
    prev = 0;
  endtask
  task automatic do_reset();
    @(negedge sclk);
    rst = 1;
    lrclk = 1;
    sdin = 0;
    fmt = 0;
    prev = 0;
    repeat (3) @(negedge sclk);
    q1.delete();
    q2.delete();
    rst = 0;
  endtask
  initial begin
    logic [15:0] wl[6], wr[6];
    tv[0] = '{0, 1, 32, 24'h00C491, 24'hFFFFFF, 24'h00C491, 24'hFFFFFF, 0};
    tv[1] = '{0, 1, 32, 24'h00C491, 24'hFFFFFF, 24'h00C491, 24'hFFFFFF, 0};
    tv[2] = '{1, 1, 32, 24'h000000, 24'h0085C5, 24'h000000, 24'h0042E2, 0};
    tv[3] = '{1, 0, 32, 24'hA5A5A5, 24'h3C3C3C, 24'hA5A5A5, 24'h3C3C3C, 0};
    tv[4] = '{0, 0, 32, 24'hC00001, 24'h800003, 24'h800002, 24'h000006, 0};
    tv[5] = '{0, 1, 16, 24'hABCD00, 24'h123400, 24'hABCD00, 24'h123400, 1};
    tv[6] = '{0, 1, 32, 24'h7E0001, 24'h00FF00, 24'h7E0001, 24'h00FF00, 0};
    tv[7] = '{1, 0, 24, 24'h135799, 24'h2468AC, 24'h135799, 24'h2468AC, 0};
    tv[8] = '{0, 1, 40, 24'hFEDCBA, 24'h000001, 24'hFEDCBA, 24'h000001, 0};
    do_reset();
    chk("rst_left", l1, 0);
    chk("rst_right", r1, 0);
    chk("rst_dvalid", dv1, 0);
    chk("rst_err", e1, 0);
    repeat (15) begin
      @(negedge sclk);
      lrclk = 1;
      sdin = 1'($urandom);
    end
    chk("sync_no_dvalid", q1.size(), 0);
    for (int i = 0; i < 9; i++) begin
      send_frame(tv[i].f, tv[i].dly, {tv[i].l, 40'h0}, {tv[i].r, 40'h0}, tv[i].slen);
      rs[i] = r_start;
    end
    flush();
    chk("vec_count", q1.size(), 9);
    for (int i = 0; i < 9 && i < q1.size(); i++) begin
      chk($sformatf("vec%0d_left", i), q1[i].l, tv[i].el);
      chk($sformatf("vec%0d_right", i), q1[i].r, tv[i].er);
      chk($sformatf("vec%0d_err", i), q1[i].e, tv[i].ee);
    end
    if (q1.size() > 3) chk("latency", q1[3].c - rs[3], 25);
    chk("hold_left", l1, 24'hFEDCBA);
    chk("hold_right", r1, 24'h000001);
    chk("hold_dvalid", dv1, 0);
    do_reset();
    send_frame(0, 1, {24'h00C491, 40'h0}, {24'hFFFFFF, 40'h0}, 32);
    send_slot(0, 0, 1, {24'h5A5A5A, 40'h0}, 11);
    @(negedge sclk);
    rst = 1;
    #1;
    chk("midrst_left", l1, 0);
    chk("midrst_right", r1, 0);
    chk("midrst_dvalid", dv1, 0);
    chk("midrst_err", e1, 0);
    lrclk = 1;
    sdin = 0;
    prev = 0;
    repeat (2) @(negedge sclk);
    q1.delete();
    rst = 0;
    repeat (5) @(negedge sclk);
    send_frame(0, 1, {24'h5A5A5A, 40'h0}, {24'h0F0F0F, 40'h0}, 32);
    flush();
    chk("postrst_count", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("postrst_left", q1[0].l, 24'h5A5A5A);
      chk("postrst_right", q1[0].r, 24'h0F0F0F);
      chk("postrst_err", q1[0].e, 0);
    end
    do_reset();
    for (int k = 0; k < 6; k++) begin
      wl[k] = 16'($urandom);
      wr[k] = 16'($urandom);
      send_frame(0, 1, {wl[k], 48'h0}, {wr[k], 48'h0}, 64);
    end
    flush();
    chk("sweep_count16", q2.size(), 6);
    chk("sweep_count24", q1.size(), 6);
    for (int k = 0; k < 6 && k < q2.size() && k < q1.size(); k++) begin
      chk($sformatf("sweep%0d_left16", k), q2[k].l, {8'h0, wl[k]});
      chk($sformatf("sweep%0d_right16", k), q2[k].r, {8'h0, wr[k]});
      chk($sformatf("sweep%0d_err16", k), q2[k].e, 0);
      chk($sformatf("sweep%0d_left24", k), q1[k].l, {wl[k], 8'h0});
      chk($sformatf("sweep%0d_err24", k), q1[k].e, 0);
      if (k > 0) chk($sformatf("sweep%0d_period", k), q2[k].c - q2[k-1].c, 128);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
